ex_div: RTL and testbench
=========================

EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 SHALL have parameter DW, default 32, operand/result width.
REQ-002 SHALL have clk  input  1  rising-edge clock.
REQ-003 SHALL have rstn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have div_start_i  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have div_op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have div_dividend_i  input  DW  rs1 operand.
REQ-007 SHALL have div_divisor_i  input  DW  rs2 operand.
REQ-008 SHALL have div_rd_addr_i  input  5  destination register.
REQ-009 SHALL have div_flush_i  input  1  abort in-flight operation, driven from the pipeline-flush path.
REQ-010 SHALL have div_hold_o  output  1  stall request to the pipeline controller's EX hold input.
REQ-011 SHALL have div_busy_o  output  1  state is not IDLE.
REQ-012 SHALL have div_ready_o  output  1  one-cycle result-valid pulse.
REQ-013 SHALL have div_result_o  output  DW  quotient or remainder per the latched op.
REQ-014 SHALL have div_rd_addr_o  output  5  latched destination register.
REQ-015 SHALL have div_we_o  output  1  register write enable, equal to div_ready_o.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, END.
REQ-017 IDLE + div_start_i + !div_flush_i SHALL latch op, rd_addr, operand signs, and absolute operand values. Operands are taken as signed only for DIV/REM.
REQ-018 From IDLE, a divisor == 0 SHALL go directly to END with: quotient all ones, remainder = dividend.
REQ-019 From IDLE, signed op with dividend == 2^(DW-1) and divisor == all ones SHALL go directly to END with: quotient = dividend, remainder = 0.
REQ-020 Otherwise IDLE SHALL go to CALC and clear a 6-bit iteration counter.
REQ-021 CALC SHALL perform one restoring shift-subtract step per cycle for exactly DW cycles, then go to END.
REQ-022 Each step: partial remainder shifted left by 1 with the next dividend MSB; subtract divisor at DW+1 bits; if non-negative, keep the difference and shift in quotient bit 1, else restore and shift in 0.
REQ-023 Signed fix-up SHALL happen on the CALC->END transition:
- quotient negated iff the dividend and divisor signs differ;
- remainder negated iff the dividend was negative.
REQ-024 END SHALL last exactly one cycle, then return to IDLE; div_ready_o and div_we_o are high only in END.
REQ-025 div_result_o and div_rd_addr_o SHALL be registered, held stable from END until the next start is accepted, and 0 after reset.
REQ-026 Latency:
- normal operations: ready exactly DW+1 cycles after the start-sampling edge (33 for DW=32);
- special cases: ready 1 cycle after that edge.
REQ-027 div_hold_o SHALL be combinational: (IDLE & div_start_i & !div_flush_i) | CALC. It SHALL be low in END so the pipeline advances with the result.
REQ-028 div_start_i while not IDLE SHALL be ignored; no queuing.
REQ-029 div_flush_i in CALC or END SHALL force IDLE next cycle with no ready pulse. A flush in END SHALL suppress div_we_o in that cycle.
REQ-030 Simultaneous div_start_i and div_flush_i in IDLE SHALL leave the FSM in IDLE.

Reset
REQ-031 rstn low at a clock edge SHALL, at any state including mid-CALC, force:
- IDLE, with the counter at 0;
- div_ready_o, div_we_o and div_hold_o low;
- div_result_o and div_rd_addr_o at 0.
REQ-032 The first start after reset release SHALL be accepted normally.

Verification
REQ-033 DIVU 100/7, rd=5 -> hold high 33 cycles, then ready pulse with result 14, rd_addr_o=5, we=1.
REQ-034 DIV -7/2 -> result 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REMU 7/0xFFFFFFFE -> 7.
REQ-035 Divide by zero, and DIV 0x80000000/0xFFFFFFFF -> ready 1 cycle after start:
- DIVU x/0 -> 0xFFFFFFFF;
- REM x/0 -> x;
- DIV overflow -> 0x80000000;
- REM overflow -> 0.
REQ-036 Start DIV 1000/3, assert div_flush_i at CALC cycle 10 -> IDLE next cycle, no ready or we pulse, hold low, next start completes correctly.
REQ-037 Start, pulse rstn low at CALC cycle 20 -> all outputs 0 and FSM in IDLE. A second div_start_i during CALC -> ignored; only one ready pulse, for the first operation.

Source files
------------

// File: rtl/ex_div.sv
// Iterative restoring divider for the EX stage: DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and complete in a single cycle.
module ex_div #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          div_start_i,
    input  logic [1:0]    div_op_i,
    input  logic [DW-1:0] div_dividend_i,
    input  logic [DW-1:0] div_divisor_i,
    input  logic [4:0]    div_rd_addr_i,
    input  logic          div_flush_i,
    output logic          div_hold_o,
    output logic          div_busy_o,
    output logic          div_ready_o,
    output logic [DW-1:0] div_result_o,
    output logic [4:0]    div_rd_addr_o,
    output logic          div_we_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_END
    } state_t;

    localparam logic [5:0]    LAST_STEP = 6'(DW - 1);
    localparam logic [DW-1:0] MIN_NEG   = {1'b1, {(DW-1){1'b0}}};

    state_t        state_reg, state_next;
    logic [5:0]    cnt_reg;
    logic          op_rem_reg;
    logic [4:0]    rd_reg;
    logic          dvd_neg_reg, dvs_neg_reg;
    logic [DW-1:0] dq_reg, rem_reg, dvs_reg;
    logic [DW-1:0] result_reg;
    logic [4:0]    rd_out_reg;

    logic          signed_op, dvd_neg_in, dvs_neg_in;
    logic [DW-1:0] dvd_abs, dvs_abs;
    logic          div_zero, overflow, special, start_ok, last_step;
    logic [DW-1:0] special_result;
    logic [DW:0]   shifted, diff;
    logic          q_bit;
    logic [DW-1:0] rem_step, dq_step, q_fix, r_fix, calc_result;

    // Operand preparation at start: signs only matter for DIV/REM.
    always_comb begin
        signed_op  = ~div_op_i[0];
        dvd_neg_in = signed_op & div_dividend_i[DW-1];
        dvs_neg_in = signed_op & div_divisor_i[DW-1];
        dvd_abs    = dvd_neg_in ? -div_dividend_i : div_dividend_i;
        dvs_abs    = dvs_neg_in ? -div_divisor_i : div_divisor_i;
        div_zero   = (div_divisor_i == '0);
        overflow   = signed_op && (div_dividend_i == MIN_NEG) && (div_divisor_i == '1);
        special    = div_zero | overflow;
        if (div_zero)
            special_result = div_op_i[1] ? div_dividend_i : '1;
        else
            special_result = div_op_i[1] ? '0 : div_dividend_i;
        start_ok   = (state_reg == S_IDLE) && div_start_i && !div_flush_i;
    end

    // One restoring step; dq_reg shifts the dividend out and the quotient in.
    always_comb begin
        shifted     = {rem_reg, dq_reg[DW-1]};
        diff        = shifted - {1'b0, dvs_reg};
        q_bit       = ~diff[DW];
        rem_step    = q_bit ? diff[DW-1:0] : shifted[DW-1:0];
        dq_step     = {dq_reg[DW-2:0], q_bit};
        q_fix       = (dvd_neg_reg ^ dvs_neg_reg) ? -dq_step : dq_step;
        r_fix       = dvd_neg_reg ? -rem_step : rem_step;
        calc_result = op_rem_reg ? r_fix : q_fix;
        last_step   = (cnt_reg == LAST_STEP);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start_ok)
                    state_next = special ? S_END : S_CALC;
            end
            S_CALC: begin
                if (div_flush_i)
                    state_next = S_IDLE;
                else if (last_step)
                    state_next = S_END;
            end
            S_END:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            op_rem_reg  <= 1'b0;
            rd_reg      <= '0;
            dvd_neg_reg <= 1'b0;
            dvs_neg_reg <= 1'b0;
            dq_reg      <= '0;
            rem_reg     <= '0;
            dvs_reg     <= '0;
            result_reg  <= '0;
            rd_out_reg  <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (start_ok) begin
                        op_rem_reg  <= div_op_i[1];
                        rd_reg      <= div_rd_addr_i;
                        dvd_neg_reg <= dvd_neg_in;
                        dvs_neg_reg <= dvs_neg_in;
                        dq_reg      <= dvd_abs;
                        dvs_reg     <= dvs_abs;
                        rem_reg     <= '0;
                        cnt_reg     <= '0;
                        if (special) begin
                            result_reg <= special_result;
                            rd_out_reg <= div_rd_addr_i;
                        end
                    end
                end
                S_CALC: begin
                    if (!div_flush_i) begin
                        dq_reg  <= dq_step;
                        rem_reg <= rem_step;
                        cnt_reg <= cnt_reg + 6'd1;
                        if (last_step) begin
                            result_reg <= calc_result;
                            rd_out_reg <= rd_reg;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // A flush landing in END kills the write-back pulse in that same cycle.
    assign div_hold_o    = rstn & (start_ok | (state_reg == S_CALC));
    assign div_busy_o    = (state_reg != S_IDLE);
    assign div_ready_o   = (state_reg == S_END) & ~div_flush_i;
    assign div_we_o      = div_ready_o;
    assign div_result_o  = result_reg;
    assign div_rd_addr_o = rd_out_reg;

endmodule

// File: tb/tb_ex_div.sv
// Directed and randomized checks of ex_div against an arithmetic reference model.
module tb_ex_div;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          div_start_i;
    logic [1:0]    div_op_i;
    logic [DW-1:0] div_dividend_i;
    logic [DW-1:0] div_divisor_i;
    logic [4:0]    div_rd_addr_i;
    logic          div_flush_i;
    logic          div_hold_o;
    logic          div_busy_o;
    logic          div_ready_o;
    logic [DW-1:0] div_result_o;
    logic [4:0]    div_rd_addr_o;
    logic          div_we_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_div #(.DW(DW)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .div_start_i    (div_start_i),
        .div_op_i       (div_op_i),
        .div_dividend_i (div_dividend_i),
        .div_divisor_i  (div_divisor_i),
        .div_rd_addr_i  (div_rd_addr_i),
        .div_flush_i    (div_flush_i),
        .div_hold_o     (div_hold_o),
        .div_busy_o     (div_busy_o),
        .div_ready_o    (div_ready_o),
        .div_result_o   (div_result_o),
        .div_rd_addr_o  (div_rd_addr_o),
        .div_we_o       (div_we_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension semantics, including the two architected corner cases.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'h0)
            return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'h0 : a;
        case (op)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        div_op_i       = op;
        div_dividend_i = a;
        div_divisor_i  = b;
        div_rd_addr_i  = rd;
        div_start_i    = 1'b1;
    endtask

    // Full transaction: starts at a negedge, returns at the negedge after the ready cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        logic [31:0] exp;
        int exp_lat, lat, hold_cnt;
        logic special;
        exp     = ref_div(op, a, b);
        special = (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        exp_lat = special ? 1 : DW + 1;
        @(negedge clk);
        drive_start(op, a, b, rd);
        #1;
        hold_cnt = div_hold_o ? 1 : 0;
        @(negedge clk);
        div_start_i = 1'b0;
        lat = 1;
        while (!div_ready_o && lat < 100) begin
            if (div_hold_o) hold_cnt++;
            @(negedge clk);
            lat++;
        end
        $display("op=%0d a=0x%08h b=0x%08h rd=%0d -> result=0x%08h exp=0x%08h lat=%0d",
                 op, a, b, rd, div_result_o, exp, lat);
        check("latency", lat, exp_lat);
        check("hold_cycles", hold_cnt, exp_lat);
        check("result", div_result_o, exp);
        check("rd_addr", {27'd0, div_rd_addr_o}, {27'd0, rd});
        check("we", {31'd0, div_we_o}, 32'd1);
        check("hold_in_end", {31'd0, div_hold_o}, 32'd0);
        @(negedge clk);
        check("ready_pulse_once", {31'd0, div_ready_o}, 32'd0);
        check("result_held", div_result_o, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        logic [31:0] seen_result;
        logic [4:0]  seen_rd;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        rstn = 1'b0;
        div_start_i = 1'b0;
        div_op_i = 2'b00;
        div_dividend_i = '0;
        div_divisor_i = '0;
        div_rd_addr_i = '0;
        div_flush_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_result", div_result_o, 32'd0);
        check("rst_rd", {27'd0, div_rd_addr_o}, 32'd0);
        check("rst_ready", {31'd0, div_ready_o}, 32'd0);
        check("rst_we", {31'd0, div_we_o}, 32'd0);
        check("rst_hold", {31'd0, div_hold_o}, 32'd0);
        check("rst_busy", {31'd0, div_busy_o}, 32'd0);
        rstn = 1'b1;

        // Architected directed cases.
        run_op(2'b01, 32'd100, 32'd7, 5'd5);
        run_op(2'b00, -32'sd7, 32'd2, 5'd1);
        run_op(2'b10, -32'sd7, 32'd2, 5'd2);
        run_op(2'b11, 32'd7, 32'hFFFF_FFFE, 5'd3);
        run_op(2'b01, 32'h1234_5678, 32'd0, 5'd4);
        run_op(2'b10, 32'hDEAD_BEEF, 32'd0, 5'd6);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);

        // Start together with flush in IDLE is dropped.
        @(negedge clk);
        drive_start(2'b01, 32'd50, 32'd5, 5'd10);
        div_flush_i = 1'b1;
        #1;
        check("start_flush_hold", {31'd0, div_hold_o}, 32'd0);
        @(negedge clk);
        div_start_i = 1'b0;
        div_flush_i = 1'b0;
        check("start_flush_busy", {31'd0, div_busy_o}, 32'd0);

        // Flush in CALC cycle 10: back to IDLE, no write-back.
        @(negedge clk);
        drive_start(2'b00, 32'd1000, 32'd3, 5'd11);
        @(negedge clk);
        div_start_i = 1'b0;
        repeat (9) @(negedge clk);
        div_flush_i = 1'b1;
        @(negedge clk);
        div_flush_i = 1'b0;
        check("flush_busy", {31'd0, div_busy_o}, 32'd0);
        check("flush_hold", {31'd0, div_hold_o}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (div_ready_o || div_we_o) pulses++;
            @(negedge clk);
        end
        check("flush_no_ready", pulses, 0);
        run_op(2'b00, 32'd1000, 32'd3, 5'd12);

        // Flush in END suppresses the write enable.
        @(negedge clk);
        drive_start(2'b01, 32'd9, 32'd0, 5'd13);
        @(negedge clk);
        div_start_i = 1'b0;
        div_flush_i = 1'b1;
        #1;
        check("end_flush_ready", {31'd0, div_ready_o}, 32'd0);
        check("end_flush_we", {31'd0, div_we_o}, 32'd0);
        @(negedge clk);
        div_flush_i = 1'b0;
        check("end_flush_idle", {31'd0, div_busy_o}, 32'd0);

        // Reset in CALC cycle 20.
        @(negedge clk);
        drive_start(2'b00, 32'd1000, 32'd3, 5'd14);
        @(negedge clk);
        div_start_i = 1'b0;
        repeat (19) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'd0, div_busy_o}, 32'd0);
        check("midrst_ready", {31'd0, div_ready_o}, 32'd0);
        check("midrst_we", {31'd0, div_we_o}, 32'd0);
        check("midrst_hold", {31'd0, div_hold_o}, 32'd0);
        check("midrst_result", div_result_o, 32'd0);
        check("midrst_rd", {27'd0, div_rd_addr_o}, 32'd0);
        rstn = 1'b1;
        run_op(2'b01, 32'd1000, 32'd3, 5'd15);

        // A second start while busy is ignored.
        @(negedge clk);
        drive_start(2'b01, 32'd500, 32'd7, 5'd3);
        @(negedge clk);
        div_start_i = 1'b0;
        repeat (5) @(negedge clk);
        drive_start(2'b01, 32'd9, 32'd2, 5'd9);
        @(negedge clk);
        div_start_i = 1'b0;
        pulses = 0;
        seen_result = '0;
        seen_rd = '0;
        for (int i = 0; i < 80; i++) begin
            if (div_ready_o) begin
                pulses++;
                seen_result = div_result_o;
                seen_rd = div_rd_addr_o;
            end
            @(negedge clk);
        end
        check("busy_start_pulses", pulses, 1);
        check("busy_start_result", seen_result, 32'd71);
        check("busy_start_rd", {27'd0, seen_rd}, 32'd3);

        // Randomized operations with corner-biased operands.
        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom_range(0, 60); rb = $urandom_range(1, 9); end
                3: begin ra = -$urandom_range(0, 60); rb = $urandom_range(1, 9); end
                4: begin ra = $urandom_range(0, 60); rb = -$urandom_range(1, 9); end
                default: ;
            endcase
            run_op(rop, ra, rb, 5'($urandom_range(0, 31)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
